// File: rtl/avmm_csr_responder.sv
// Avalon-MM CSR responder with programmable wait states, a free-running
// cycle counter, a completed-transaction counter and an error counter.
module avmm_csr_responder #(
    parameter int                    ADDRESS_WIDTH = 32,
    parameter int                    DATA_WIDTH    = 32,
    parameter int                    WAIT_CYCLES   = 2,
    parameter logic [DATA_WIDTH-1:0] ID_VALUE      = DATA_WIDTH'(32'h5A5A_0001)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ADDRESS_WIDTH-1:0] s0_addr,
    input  logic                     s0_read,
    input  logic                     s0_write,
    input  logic [DATA_WIDTH-1:0]    s0_writedata,
    output logic [DATA_WIDTH-1:0]    s0_readdata,
    output logic                     s0_waitrequest
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_t;

    localparam logic [3:0] ADDR_ID      = 4'h0;
    localparam logic [3:0] ADDR_SCRATCH = 4'h1;
    localparam logic [3:0] ADDR_CONTROL = 4'h2;
    localparam logic [3:0] ADDR_COUNTER = 4'h3;
    localparam logic [3:0] ADDR_XACT    = 4'h4;
    localparam logic [3:0] ADDR_ERR     = 4'h5;

    state_t                  state;
    state_t                  state_nxt;
    logic [7:0]              wait_cnt;

    logic [3:0]              req_addr;
    logic [DATA_WIDTH-1:0]   req_wdata;
    logic                    req_rd;
    logic                    req_wr;

    logic [DATA_WIDTH-1:0]   scratch;
    logic                    cnt_en;
    logic [DATA_WIDTH-1:0]   counter;
    logic [DATA_WIDTH-1:0]   xact_count;
    logic [DATA_WIDTH-1:0]   err_count;

    logic [3:0]              cur_addr;
    logic                    cur_rd;
    logic                    cur_wr;
    logic [DATA_WIDTH-1:0]   rd_mux;
    logic                    enter_ack;
    logic                    in_ack;
    logic                    abort;
    logic                    req_mapped;
    logic                    do_write;
    logic                    err_event;
    logic                    unused_addr;

    // Upper address bits alias onto the 16-word map and are deliberately ignored.
    assign unused_addr = ^s0_addr[ADDRESS_WIDTH-1:4];

    // Next-state and waitrequest decode; waitrequest drops only while in ACK.
    always_comb begin
        state_nxt      = state;
        s0_waitrequest = 1'b1;
        case (state)
            S_IDLE: begin
                if (s0_read || s0_write) begin
                    state_nxt = (WAIT_CYCLES > 0) ? S_WAIT : S_ACK;
                end
            end
            S_WAIT: begin
                if (!s0_read && !s0_write) begin
                    state_nxt = S_IDLE;
                end else if (wait_cnt <= 8'd1) begin
                    state_nxt = S_ACK;
                end
            end
            S_ACK: begin
                s0_waitrequest = 1'b0;
                state_nxt      = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // With zero wait states ACK is entered straight from IDLE before the latch is loaded, so read from the live bus there.
    always_comb begin
        cur_addr = req_addr;
        cur_rd   = req_rd;
        cur_wr   = req_wr;
        if (state == S_IDLE) begin
            cur_addr = s0_addr[3:0];
            cur_rd   = s0_read;
            cur_wr   = s0_write;
        end
    end

    // Register read multiplexer; unmapped words and write-only bits read as zero.
    always_comb begin
        rd_mux = '0;
        case (cur_addr)
            ADDR_ID:      rd_mux = ID_VALUE;
            ADDR_SCRATCH: rd_mux = scratch;
            ADDR_CONTROL: rd_mux = {{(DATA_WIDTH-1){1'b0}}, cnt_en};
            ADDR_COUNTER: rd_mux = counter;
            ADDR_XACT:    rd_mux = xact_count;
            ADDR_ERR:     rd_mux = err_count;
            default:      rd_mux = '0;
        endcase
    end

    assign enter_ack  = (state_nxt == S_ACK) && (state != S_ACK);
    assign in_ack     = (state == S_ACK);
    assign abort      = (state == S_WAIT) && !s0_read && !s0_write;
    assign req_mapped = (req_addr <= ADDR_ERR);
    assign do_write   = in_ack && req_wr && !req_rd && req_mapped;
    assign err_event  = abort || (in_ack && ((req_rd && req_wr) || !req_mapped));

    // State register and wait-state down-counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE) begin
                wait_cnt <= 8'(WAIT_CYCLES);
            end else if (state == S_WAIT) begin
                wait_cnt <= wait_cnt - 8'd1;
            end
        end
    end

    // Capture the request in IDLE; the master holds the bus stable, so these copies drive the rest of the transaction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_addr  <= '0;
            req_wdata <= '0;
            req_rd    <= 1'b0;
            req_wr    <= 1'b0;
        end else if ((state == S_IDLE) && (s0_read || s0_write)) begin
            req_addr  <= s0_addr[3:0];
            req_wdata <= s0_writedata;
            req_rd    <= s0_read;
            req_wr    <= s0_write;
        end
    end

    // Read data is loaded on the edge into ACK; writes and read+write collisions return zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s0_readdata <= '0;
        end else if (enter_ack) begin
            s0_readdata <= (cur_rd && !cur_wr) ? rd_mux : '0;
        end
    end

    // Writable registers commit at the end of the ACK cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scratch <= '0;
            cnt_en  <= 1'b0;
        end else if (do_write) begin
            if (req_addr == ADDR_SCRATCH) begin
                scratch <= req_wdata;
            end
            if (req_addr == ADDR_CONTROL) begin
                cnt_en <= req_wdata[0];
            end
        end
    end

    // Free-running cycle counter; a CNT_CLR write overrides the increment in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            counter <= '0;
        end else if (do_write && (req_addr == ADDR_CONTROL) && req_wdata[1]) begin
            counter <= '0;
        end else if (cnt_en) begin
            counter <= counter + 1'b1;
        end
    end

    // Every completed ACK counts, including no-op and unmapped transfers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            xact_count <= '0;
        end else if (in_ack) begin
            xact_count <= xact_count + 1'b1;
        end
    end

    // Error counter saturates; a transaction raises at most one error event.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_count <= '0;
        end else if (err_event && (err_count != '1)) begin
            err_count <= err_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_avmm_csr_responder.sv
// Directed testbench for avmm_csr_responder, with a second zero-wait-state instance.
module tb_avmm_csr_responder;

    localparam int          W      = 2;
    localparam logic [31:0] ID_VAL = 32'h5A5A_0001;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] s0_addr;
    logic        s0_read;
    logic        s0_write;
    logic [31:0] s0_writedata;
    logic [31:0] rdata;
    logic        wreq;
    logic [31:0] rdata0;
    logic        wreq0;

    int cyc = 0;
    int tests = 0;
    int fails = 0;

    avmm_csr_responder #(
        .ADDRESS_WIDTH(32),
        .DATA_WIDTH(32),
        .WAIT_CYCLES(W),
        .ID_VALUE(ID_VAL)
    ) dut (
        .clk(clk),
        .reset(reset),
        .s0_addr(s0_addr),
        .s0_read(s0_read),
        .s0_write(s0_write),
        .s0_writedata(s0_writedata),
        .s0_readdata(rdata),
        .s0_waitrequest(wreq)
    );

    avmm_csr_responder #(
        .ADDRESS_WIDTH(32),
        .DATA_WIDTH(32),
        .WAIT_CYCLES(0),
        .ID_VALUE(ID_VAL)
    ) dut0 (
        .clk(clk),
        .reset(reset),
        .s0_addr(s0_addr),
        .s0_read(s0_read),
        .s0_write(s0_write),
        .s0_writedata(s0_writedata),
        .s0_readdata(rdata0),
        .s0_waitrequest(wreq0)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Cycle index, stable between rising edges.
    always @(posedge clk) cyc <= cyc + 1;

    // Present one request on the next falling edge and hold it until waitrequest drops (bounded).
    task automatic do_xact(input logic rd_i, input logic wr_i, input logic [31:0] a,
                           input logic [31:0] d, output logic [31:0] data,
                           output int lat, output int ack_cyc);
        @(negedge clk);
        s0_read      = rd_i;
        s0_write     = wr_i;
        s0_addr      = a;
        s0_writedata = d;
        lat          = -1;
        ack_cyc      = -1;
        data         = '0;
        for (int k = 0; k <= 20; k++) begin
            if (k > 0) @(negedge clk);
            if (wreq === 1'b0) begin
                lat     = k;
                ack_cyc = cyc;
                data    = rdata;
                break;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            s0_read  = 1'b0;
            s0_write = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        s0_read  = 1'b0;
        s0_write = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        s0_read      = 1'b0;
        s0_write     = 1'b0;
        s0_addr      = '0;
        s0_writedata = '0;
        repeat (2) @(negedge clk);
        tests++;
        if (wreq !== 1'b1) begin
            fails++;
            $display("[TB] FAIL reset_waitrequest: got %b expected 1", wreq);
        end
        tests++;
        if (rdata !== 32'h0) begin
            fails++;
            $display("[TB] FAIL reset_readdata: got %h expected 0", rdata);
        end
        reset = 1'b0;
        @(negedge clk);
        tests++;
        if (wreq !== 1'b1) begin
            fails++;
            $display("[TB] FAIL idle_waitrequest: got %b expected 1", wreq);
        end
    endtask

    task automatic test_id_read();
        logic [31:0] d;
        int lat, ac;
        do_xact(1'b1, 1'b0, 32'h0, 32'h0, d, lat, ac);
        tests++;
        if (lat !== W + 1) begin
            fails++;
            $display("[TB] FAIL id_latency: got %0d expected %0d", lat, W + 1);
        end
        tests++;
        if (d !== ID_VAL) begin
            fails++;
            $display("[TB] FAIL id_value: got %h expected %h", d, ID_VAL);
        end
        do_xact(1'b1, 1'b0, 32'h4, 32'h0, d, lat, ac);
        tests++;
        if (lat !== W + 1) begin
            fails++;
            $display("[TB] FAIL b2b_latency: got %0d expected %0d", lat, W + 1);
        end
        tests++;
        if (d !== 32'd1) begin
            fails++;
            $display("[TB] FAIL xact_after_id: got %h expected 1", d);
        end
        idle(1);
    endtask

    task automatic test_scratch();
        logic [31:0] d;
        int lat, ac;
        do_xact(1'b0, 1'b1, 32'h1, 32'hDEAD_BEEF, d, lat, ac);
        do_xact(1'b1, 1'b0, 32'h1, 32'h0, d, lat, ac);
        tests++;
        if (d !== 32'hDEAD_BEEF) begin
            fails++;
            $display("[TB] FAIL scratch_rw: got %h expected deadbeef", d);
        end
        do_xact(1'b0, 1'b1, 32'h0, 32'h0, d, lat, ac);
        do_xact(1'b1, 1'b0, 32'hFFFF_FFF0, 32'h0, d, lat, ac);
        tests++;
        if (d !== ID_VAL) begin
            fails++;
            $display("[TB] FAIL id_after_write_alias: got %h expected %h", d, ID_VAL);
        end
        do_xact(1'b1, 1'b0, 32'h5, 32'h0, d, lat, ac);
        tests++;
        if (d !== 32'h0) begin
            fails++;
            $display("[TB] FAIL err_after_ro_write: got %h expected 0", d);
        end
        idle(1);
    endtask

    task automatic test_counter();
        logic [31:0] d, v1, v2;
        int lat, a1, r1, r2, a2, r3;
        do_xact(1'b0, 1'b1, 32'h2, 32'h1, d, lat, a1);
        idle(10);
        do_xact(1'b1, 1'b0, 32'h3, 32'h0, v1, lat, r1);
        do_xact(1'b1, 1'b0, 32'h3, 32'h0, v2, lat, r2);
        tests++;
        if (v2 - v1 !== 32'(W + 2)) begin
            fails++;
            $display("[TB] FAIL counter_delta: got %0d expected %0d", v2 - v1, W + 2);
        end
        tests++;
        if (v1 !== 32'(r1 - a1 - 2)) begin
            fails++;
            $display("[TB] FAIL counter_value: got %0d expected %0d", v1, r1 - a1 - 2);
        end
        do_xact(1'b1, 1'b0, 32'h2, 32'h0, d, lat, r2);
        tests++;
        if (d !== 32'h1) begin
            fails++;
            $display("[TB] FAIL control_read: got %h expected 1", d);
        end
        do_xact(1'b0, 1'b1, 32'h2, 32'h3, d, lat, a2);
        idle(5);
        do_xact(1'b1, 1'b0, 32'h3, 32'h0, d, lat, r3);
        tests++;
        if (d !== 32'(r3 - a2 - 2)) begin
            fails++;
            $display("[TB] FAIL counter_clear: got %0d expected %0d", d, r3 - a2 - 2);
        end
        idle(1);
    endtask

    task automatic test_errors();
        logic [31:0] d;
        int lat, ac;
        do_xact(1'b1, 1'b0, 32'h7, 32'h0, d, lat, ac);
        tests++;
        if (d !== 32'h0) begin
            fails++;
            $display("[TB] FAIL unmapped_read: got %h expected 0", d);
        end
        do_xact(1'b0, 1'b1, 32'h9, 32'h1111_2222, d, lat, ac);
        tests++;
        if (d !== 32'h0) begin
            fails++;
            $display("[TB] FAIL unmapped_write: got %h expected 0", d);
        end
        do_xact(1'b1, 1'b1, 32'h1, 32'h1234_5678, d, lat, ac);
        tests++;
        if (lat !== W + 1) begin
            fails++;
            $display("[TB] FAIL collision_latency: got %0d expected %0d", lat, W + 1);
        end
        tests++;
        if (d !== 32'h0) begin
            fails++;
            $display("[TB] FAIL collision_readdata: got %h expected 0", d);
        end
        do_xact(1'b1, 1'b0, 32'h1, 32'h0, d, lat, ac);
        tests++;
        if (d !== 32'hDEAD_BEEF) begin
            fails++;
            $display("[TB] FAIL scratch_unchanged: got %h expected deadbeef", d);
        end
        do_xact(1'b1, 1'b0, 32'h5, 32'h0, d, lat, ac);
        tests++;
        if (d !== 32'd3) begin
            fails++;
            $display("[TB] FAIL err_count_three: got %0d expected 3", d);
        end
        idle(1);
    endtask

    task automatic test_abort();
        logic [31:0] d, x;
        int lat, ac, lows;
        do_xact(1'b1, 1'b0, 32'h4, 32'h0, x, lat, ac);
        idle(1);
        @(negedge clk);
        s0_read  = 1'b1;
        s0_write = 1'b0;
        s0_addr  = 32'h1;
        @(negedge clk);
        s0_read = 1'b0;
        lows    = (wreq === 1'b1) ? 0 : 1;
        repeat (5) begin
            @(negedge clk);
            if (wreq !== 1'b1) lows++;
        end
        tests++;
        if (lows !== 0) begin
            fails++;
            $display("[TB] FAIL abort_no_ack: got %0d ack cycles expected 0", lows);
        end
        do_xact(1'b1, 1'b0, 32'h5, 32'h0, d, lat, ac);
        tests++;
        if (d !== 32'd4) begin
            fails++;
            $display("[TB] FAIL abort_err_count: got %0d expected 4", d);
        end
        do_xact(1'b1, 1'b0, 32'h4, 32'h0, d, lat, ac);
        tests++;
        if (d !== x + 32'd2) begin
            fails++;
            $display("[TB] FAIL abort_xact_count: got %0d expected %0d", d, x + 32'd2);
        end
        idle(1);
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        int lat, ac;
        @(negedge clk);
        s0_write     = 1'b1;
        s0_read      = 1'b0;
        s0_addr      = 32'h1;
        s0_writedata = 32'hCAFE_0000;
        @(negedge clk);
        reset = 1'b1;
        #1;
        tests++;
        if (wreq !== 1'b1 || rdata !== 32'h0) begin
            fails++;
            $display("[TB] FAIL reset_mid_outputs: got wreq=%b rdata=%h expected 1/0", wreq, rdata);
        end
        @(negedge clk);
        tests++;
        if (wreq !== 1'b1) begin
            fails++;
            $display("[TB] FAIL reset_mid_hold: got %b expected 1", wreq);
        end
        @(negedge clk);
        reset    = 1'b0;
        s0_write = 1'b0;
        do_xact(1'b1, 1'b0, 32'h1, 32'h0, d, lat, ac);
        tests++;
        if (d !== 32'h0) begin
            fails++;
            $display("[TB] FAIL reset_mid_scratch: got %h expected 0", d);
        end
        idle(1);
    endtask

    task automatic test_zero_wait();
        do_reset();
        @(negedge clk);
        s0_write     = 1'b1;
        s0_read      = 1'b0;
        s0_addr      = 32'h1;
        s0_writedata = 32'h0000_0055;
        tests++;
        if (wreq0 !== 1'b1) begin
            fails++;
            $display("[TB] FAIL zw_cycle_t: got %b expected 1", wreq0);
        end
        @(negedge clk);
        tests++;
        if (wreq0 !== 1'b0) begin
            fails++;
            $display("[TB] FAIL zw_cycle_t1: got %b expected 0", wreq0);
        end
        @(negedge clk);
        s0_write = 1'b0;
        s0_read  = 1'b1;
        tests++;
        if (wreq0 !== 1'b1) begin
            fails++;
            $display("[TB] FAIL zw_cycle_t2: got %b expected 1", wreq0);
        end
        @(negedge clk);
        tests++;
        if (wreq0 !== 1'b0 || rdata0 !== 32'h0000_0055) begin
            fails++;
            $display("[TB] FAIL zw_readback: got wreq=%b rdata=%h expected 0/00000055", wreq0, rdata0);
        end
        idle(4);
    endtask

    // Run every scenario in order, then report.
    initial begin
        test_reset();
        test_id_read();
        test_scratch();
        test_counter();
        test_errors();
        test_abort();
        test_reset_mid();
        test_zero_wait();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
